cpu_multicycle: RTL and testbench



---
 rtl/cpu_multicycle_pkg.sv | 67 ++++++
 rtl/cpu_multicycle_mc_control.sv | 134 +++++++++++++
 rtl/cpu_multicycle.sv | 162 ++++++++++++++++
 tb/tb_cpu_multicycle.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_multicycle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types for the multi-cycle MIPS core: FSM states, opcode
//               and funct encodings, ALU operation encoding and ALU function.
// Revision    : 1.0 - initial multi-cycle release
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6
    } aluop_t;

    // Shifts operate on the second operand (rt) by the shamt field.
    function automatic logic [31:0] alu_eval(input aluop_t op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] shamt);
        logic [31:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_SLT: r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLL: r = b << shamt;
            ALU_SRL: r = b >> shamt;
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_multicycle_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : mc_control
// Description : State register, next-state logic and instruction decode for
//               the multi-cycle core.
// Revision    : 1.0 - initial multi-cycle release
// ============================================================================
module mc_control
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    output state_t     state_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       retire_o,
    output logic       halted_o,
    output aluop_t     aluop_o,
    output logic       imm_src_o,
    output logic       imm_zext_o,
    output logic       dst_rd_o,
    output logic       is_lw_o,
    output logic       is_sw_o,
    output logic       is_branch_o,
    output logic       is_bne_o,
    output logic       is_jump_o,
    output logic       is_jal_o
);

    state_t state_q;
    logic   retire_q;
    logic   halted_q;
    logic   w_legal;

    always_comb begin
        w_legal     = 1'b1;
        aluop_o     = ALU_ADD;
        imm_src_o   = 1'b0;
        imm_zext_o  = 1'b0;
        dst_rd_o    = 1'b0;
        is_lw_o     = 1'b0;
        is_sw_o     = 1'b0;
        is_branch_o = 1'b0;
        is_bne_o    = 1'b0;
        is_jump_o   = 1'b0;
        is_jal_o    = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                dst_rd_o = 1'b1;
                case (funct_i)
                    F_ADD:   aluop_o = ALU_ADD;
                    F_SUB:   aluop_o = ALU_SUB;
                    F_AND:   aluop_o = ALU_AND;
                    F_OR:    aluop_o = ALU_OR;
                    F_SLT:   aluop_o = ALU_SLT;
                    F_SLL:   aluop_o = ALU_SLL;
                    F_SRL:   aluop_o = ALU_SRL;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_ADDI: imm_src_o = 1'b1;
            OP_SLTI: begin imm_src_o = 1'b1; aluop_o = ALU_SLT; end
            // Logical immediates are zero-extended as in the MIPS ISA.
            OP_ANDI: begin imm_src_o = 1'b1; imm_zext_o = 1'b1; aluop_o = ALU_AND; end
            OP_ORI:  begin imm_src_o = 1'b1; imm_zext_o = 1'b1; aluop_o = ALU_OR;  end
            OP_LW:   begin imm_src_o = 1'b1; is_lw_o = 1'b1; end
            OP_SW:   begin imm_src_o = 1'b1; is_sw_o = 1'b1; end
            OP_BEQ:  is_branch_o = 1'b1;
            OP_BNE:  begin is_branch_o = 1'b1; is_bne_o = 1'b1; end
            OP_J:    is_jump_o = 1'b1;
            OP_JAL:  begin is_jump_o = 1'b1; is_jal_o = 1'b1; end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                FETCH:  if (mem_ready_i) state_q <= DECODE;
                DECODE: begin
                    if (w_legal) begin
                        state_q <= EXEC;
                    end else begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (is_lw_o || is_sw_o) begin
                        state_q <= MEM;
                    end else if (is_branch_o || is_jump_o) begin
                        state_q  <= FETCH;
                        retire_q <= 1'b1;
                    end else begin
                        state_q <= WB;
                    end
                end
                MEM: begin
                    if (mem_ready_i) begin
                        if (is_sw_o) begin
                            state_q  <= FETCH;
                            retire_q <= 1'b1;
                        end else begin
                            state_q <= WB;
                        end
                    end
                end
                WB: begin
                    state_q  <= FETCH;
                    retire_q <= 1'b1;
                end
                HALT:    state_q <= HALT;
                default: state_q <= FETCH;
            endcase
        end
    end

    // Gating with reset drops a pending request as soon as reset is applied.
    assign mem_req_o = !reset && ((state_q == FETCH) || (state_q == MEM));
    assign mem_we_o  = mem_req_o && (state_q == MEM) && is_sw_o;
    assign state_o   = state_q;
    assign retire_o  = retire_q;
    assign halted_o  = halted_q;

endmodule
`default_nettype wire

// File: rtl/cpu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : cpu_multicycle
// Description : Multi-cycle MIPS core with one shared valid/ready memory port.
//               Define CPU_PERF_COUNTERS_EN to add perf_cycles/perf_instret.
// Revision    : 1.0 - initial multi-cycle release
// ============================================================================
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NREGS    = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              halted
`ifdef CPU_PERF_COUNTERS_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_instret
`endif
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] npc_q;
    logic [31:0]       ir_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       alu_out_q;
    logic [31:0]       mdr_q;
    logic [31:0]       rf_q [NREGS];

    state_t w_state;
    aluop_t w_aluop;
    logic   w_imm_src, w_imm_zext, w_dst_rd, w_is_lw, w_is_sw;
    logic   w_is_branch, w_is_bne, w_is_jump, w_is_jal;

    mc_control u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .op_i        (ir_q[31:26]),
        .funct_i     (ir_q[5:0]),
        .mem_ready_i (mem_ready),
        .state_o     (w_state),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .retire_o    (retire),
        .halted_o    (halted),
        .aluop_o     (w_aluop),
        .imm_src_o   (w_imm_src),
        .imm_zext_o  (w_imm_zext),
        .dst_rd_o    (w_dst_rd),
        .is_lw_o     (w_is_lw),
        .is_sw_o     (w_is_sw),
        .is_branch_o (w_is_branch),
        .is_bne_o    (w_is_bne),
        .is_jump_o   (w_is_jump),
        .is_jal_o    (w_is_jal)
    );

    logic [4:0]  w_rs, w_rt, w_rd, w_waddr;
    logic [31:0] w_sext, w_imm, w_alu, w_npc32, w_br_tgt, w_j_tgt, w_wdata;
    logic        w_taken, w_mem_done, w_rf_we;

    assign w_rs       = ir_q[25:21];
    assign w_rt       = ir_q[20:16];
    assign w_rd       = ir_q[15:11];
    assign w_sext     = {{16{ir_q[15]}}, ir_q[15:0]};
    assign w_imm      = w_imm_zext ? {16'd0, ir_q[15:0]} : w_sext;
    assign w_alu      = alu_eval(w_aluop, a_q, w_imm_src ? w_imm : b_q, ir_q[10:6]);
    assign w_npc32    = 32'(npc_q);
    assign w_br_tgt   = w_npc32 + {w_sext[29:0], 2'b00};
    assign w_j_tgt    = {w_npc32[31:28], ir_q[25:0], 2'b00};
    assign w_taken    = w_is_bne ? (a_q != b_q) : (a_q == b_q);
    assign w_mem_done = mem_req && mem_ready;

    // Low address bits are forced to zero: misaligned accesses never trap.
    assign mem_addr  = !mem_req ? '0
                     : (w_state == FETCH) ? {pc_q[ADDR_W-1:2], 2'b00}
                     : {alu_out_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = mem_we ? b_q : 32'd0;

    // jal links in EXEC; every other register write happens in WB.
    assign w_rf_we = !reset && ((w_state == WB) || ((w_state == EXEC) && w_is_jal));
    assign w_waddr = w_is_jal ? 5'd31 : (w_dst_rd ? w_rd : w_rt);
    assign w_wdata = w_is_jal ? w_npc32 : (w_is_lw ? mdr_q : alu_out_q);

    always_ff @(posedge clk) begin
        if (w_rf_we && (w_waddr != 5'd0)) begin
            rf_q[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC[ADDR_W-1:0];
            npc_q     <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            case (w_state)
                FETCH: begin
                    if (w_mem_done) begin
                        ir_q  <= mem_rdata;
                        npc_q <= pc_q + ADDR_W'(4);
                    end
                end
                DECODE: begin
                    a_q <= (w_rs == 5'd0) ? 32'd0 : rf_q[w_rs];
                    b_q <= (w_rt == 5'd0) ? 32'd0 : rf_q[w_rt];
                end
                EXEC: begin
                    alu_out_q <= w_alu;
                    if (w_is_branch) begin
                        pc_q <= w_taken ? w_br_tgt[ADDR_W-1:0] : npc_q;
                    end else if (w_is_jump) begin
                        pc_q <= w_j_tgt[ADDR_W-1:0];
                    end
                end
                MEM: begin
                    if (w_mem_done) begin
                        if (w_is_sw) pc_q  <= npc_q;
                        else         mdr_q <= mem_rdata;
                    end
                end
                WB:      pc_q <= npc_q;
                default: ;
            endcase
        end
    end

`ifdef CPU_PERF_COUNTERS_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles_q  <= 32'd0;
            perf_instret_q <= 32'd0;
        end else begin
            if (w_state != HALT) perf_cycles_q  <= perf_cycles_q + 32'd1;
            if (retire)          perf_instret_q <= perf_instret_q + 32'd1;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_instret = perf_instret_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_multicycle
// Description : Directed self-checking bench for cpu_multicycle with a unified
//               memory model that inserts a configurable number of wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CPU_PERF_COUNTERS_EN
    logic [31:0] perf_cycles, perf_instret;
`endif

    logic [31:0] mem [0:255];
    logic [31:0] prog [20];
    int          wait_cfg = 0;
    int          wcnt = 0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'd0;
    logic [31:0] ld_data = 32'd0;
    logic [31:0] last_waddr = 32'd0;
    logic [31:0] last_wdata = 32'd0;
    int          wr_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;

    cpu_multicycle dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .retire       (retire),
        .halted       (halted)
`ifdef CPU_PERF_COUNTERS_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_instret (perf_instret)
`endif
    );

    always #5 clk = ~clk;

    assign mem_ready = mem_req && (wcnt >= wait_cfg);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
            last_waddr   <= 32'd0;
            last_wdata   <= 32'd0;
            wr_cnt       <= 0;
        end else if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            last_waddr         <= mem_addr;
            last_wdata         <= mem_wdata;
            wr_cnt             <= wr_cnt + 1;
        end
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hold reset, load the 20-word image at 0x00..0x4C, leave reset asserted.
    task automatic load_and_reset(input int wcfg);
        reset    = 1'b1;
        wait_cfg = wcfg;
        tick;
        ld_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ld_addr = 8'(i);
            ld_data = prog[i];
            tick;
        end
        ld_en = 1'b0;
        tick;
    endtask

    task automatic release_reset;
        reset = 1'b0;
        #1;
    endtask

    // Latency is counted in cycles from the current cycle to the retire pulse.
    task automatic wait_retire(input string tag, input int exp_n, input logic chk,
                               input logic [31:0] exp_addr);
        int n = 0;
        do begin
            tick;
            n++;
            if (chk && mem_req && !mem_we && !retire)
                check_val({tag, "_addr"}, mem_addr, exp_addr);
        end while (!retire && n < 64);
        check_val({tag, "_lat"}, n, exp_n);
    endtask

    task automatic prog_a;
        for (int i = 0; i < 20; i++) prog[i] = 32'd0;
        prog[0] = 32'h2001_0005;   // addi $1,$0,5
        prog[1] = 32'h2002_0007;   // addi $2,$0,7
        prog[2] = 32'h0022_1820;   // add  $3,$1,$2
        prog[3] = 32'hAC03_0040;   // sw   $3,0x40($0)
        prog[4] = 32'h8C04_0040;   // lw   $4,0x40($0)
        prog[5] = 32'hAC04_0044;   // sw   $4,0x44($0)
        prog[6] = 32'h1021_FFFF;   // beq  $1,$1,-1
    endtask

    task automatic run_a(input string tag, input int ws);
        wait_retire({tag, "_i0"}, 4 + ws, 1'b1, 32'h00);
        wait_retire({tag, "_i1"}, 4 + ws, 1'b1, 32'h04);
        wait_retire({tag, "_add"}, 4 + ws, 1'b1, 32'h08);
        wait_retire({tag, "_sw3"}, 4 + 2 * ws, 1'b1, 32'h0C);
        check_val({tag, "_sw3_addr"}, last_waddr, 32'h40);
        check_val({tag, "_sw3_data"}, last_wdata, 32'd12);
        wait_retire({tag, "_lw"}, 5 + 2 * ws, 1'b0, 32'h0);
        wait_retire({tag, "_sw4"}, 4 + 2 * ws, 1'b1, 32'h14);
        check_val({tag, "_sw4_addr"}, last_waddr, 32'h44);
        check_val({tag, "_sw4_data"}, last_wdata, 32'd12);
        check_val({tag, "_wr_cnt"}, wr_cnt, 2);
        wait_retire({tag, "_beq"}, 3 + ws, 1'b1, 32'h18);
        check_val({tag, "_loop_addr"}, mem_addr, 32'h18);
        wait_retire({tag, "_beq2"}, 3 + ws, 1'b1, 32'h18);
    endtask

    initial begin
        reset = 1'b1;

        // Zero-wait run of the arithmetic/load/store program.
        prog_a();
        load_and_reset(0);
        check_val("rst_req", mem_req, 1'b0);
        check_val("rst_we", mem_we, 1'b0);
        check_val("rst_addr", mem_addr, 32'h0);
        check_val("rst_wdata", mem_wdata, 32'h0);
        check_val("rst_retire", retire, 1'b0);
        check_val("rst_halted", halted, 1'b0);
`ifdef CPU_PERF_COUNTERS_EN
        check_val("rst_pcyc", perf_cycles, 32'd0);
        check_val("rst_pret", perf_instret, 32'd0);
`endif
        release_reset();
        check_val("rel_req", mem_req, 1'b1);
        check_val("rel_addr", mem_addr, 32'h0);
        run_a("z", 0);

        // Same program, three wait states on every transfer.
        prog_a();
        load_and_reset(3);
        release_reset();
        run_a("w3", 3);

        // Branch / jump program.
        for (int i = 0; i < 20; i++) prog[i] = 32'd0;
        prog[0] = 32'h2001_0001;   // addi $1,$0,1
        prog[1] = 32'h1421_0005;   // bne  $1,$1,+5 (not taken)
        prog[2] = 32'h0C00_0004;   // jal  0x10
        prog[3] = 32'hFC00_0000;   // skipped
        prog[4] = 32'hAC1F_0048;   // sw   $31,0x48($0)
        prog[5] = 32'h1021_FFFF;   // beq  $1,$1,-1
        load_and_reset(0);
        release_reset();
        wait_retire("b_addi", 4, 1'b1, 32'h00);
        wait_retire("b_bne", 3, 1'b1, 32'h04);
        check_val("b_bne_next", mem_addr, 32'h08);
        wait_retire("b_jal", 3, 1'b1, 32'h08);
        check_val("b_jal_next", mem_addr, 32'h10);
        wait_retire("b_sw31", 4, 1'b1, 32'h10);
        check_val("b_link_addr", last_waddr, 32'h48);
        check_val("b_link_data", last_wdata, 32'h0C);
        wait_retire("b_beq", 3, 1'b1, 32'h14);
        check_val("b_beq_next", mem_addr, 32'h14);
        wait_retire("b_beq2", 3, 1'b1, 32'h14);
        check_val("b_beq2_next", mem_addr, 32'h14);

        // Illegal opcode at 0x08 halts the core.
        for (int i = 0; i < 20; i++) prog[i] = 32'd0;
        prog[0] = 32'h2001_0005;
        prog[1] = 32'h2002_0007;
        prog[2] = 32'hFC00_0000;
        load_and_reset(0);
        release_reset();
        wait_retire("h_i0", 4, 1'b1, 32'h00);
        wait_retire("h_i1", 4, 1'b1, 32'h04);
        tick;
        check_val("h_dec_halted", halted, 1'b0);
        check_val("h_dec_req", mem_req, 1'b0);
        tick;
        check_val("h_halted", halted, 1'b1);
        check_val("h_req", mem_req, 1'b0);
        for (int i = 0; i < 4; i++) tick;
        check_val("h_halted_hold", halted, 1'b1);
        check_val("h_req_hold", mem_req, 1'b0);
        check_val("h_retire_hold", retire, 1'b0);
`ifdef CPU_PERF_COUNTERS_EN
        check_val("h_pcyc", perf_cycles, 32'd10);
        check_val("h_pret", perf_instret, 32'd2);
`endif
        reset = 1'b1;
        tick;
        check_val("h_rst_halted", halted, 1'b0);
        check_val("h_rst_req", mem_req, 1'b0);
        release_reset();
        check_val("h_rel_req", mem_req, 1'b1);
        check_val("h_rel_addr", mem_addr, 32'h0);
        wait_retire("h_rerun", 4, 1'b1, 32'h00);

        // Reset applied while a fetch is stalled.
        prog_a();
        load_and_reset(50);
        release_reset();
        for (int i = 0; i < 3; i++) tick;
        check_val("d_stall_req", mem_req, 1'b1);
        check_val("d_stall_addr", mem_addr, 32'h0);
        check_val("d_stall_retire", retire, 1'b0);
        reset = 1'b1;
        tick;
        check_val("d_abort_req", mem_req, 1'b0);
        check_val("d_abort_wr", wr_cnt, 0);
`ifdef CPU_PERF_COUNTERS_EN
        check_val("d_pcyc", perf_cycles, 32'd0);
        check_val("d_pret", perf_instret, 32'd0);
`endif
        wait_cfg = 0;
        tick;
        release_reset();
        check_val("d_rel_addr", mem_addr, 32'h0);
        wait_retire("d_i0", 4, 1'b1, 32'h00);
        wait_retire("d_i1", 4, 1'b1, 32'h04);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
